// File: rtl/uart_tx_arbiter.sv
// Two-requester byte-stream arbiter feeding a single 8N1 UART transmitter.
// Round-robin grants, with a packet lock that a timeout can force open.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  input  logic       s0_tlast,
  output logic       s0_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  input  logic       s1_tlast,
  output logic       s1_tready,
  output logic       uart_txd,
  output logic       busy,
  output logic       owner,
  output logic       lock_err
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic          lock_err_q, lock_err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          armed_q, armed_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;

  logic grant_s;
  logic req_s;
  logic accept_s;
  logic baud_wrap_s;

  // Arbitration: a held lock pins the grant to the owner, otherwise round-robin.
  always_comb begin
    grant_s = owner_q;
    req_s   = 1'b0;
    if (lock_q) begin
      grant_s = owner_q;
      req_s   = owner_q ? s1_tvalid : s0_tvalid;
    end else if (s0_tvalid && s1_tvalid) begin
      grant_s = ~owner_q;
      req_s   = 1'b1;
    end else if (s0_tvalid) begin
      grant_s = 1'b0;
      req_s   = 1'b1;
    end else if (s1_tvalid) begin
      grant_s = 1'b1;
      req_s   = 1'b1;
    end else begin
      grant_s = owner_q;
      req_s   = 1'b0;
    end
  end

  // armed_q keeps the first post-reset cycle from accepting anything.
  assign accept_s  = armed_q && (state_q == IDLE) && req_s;
  assign s0_tready = accept_s && !grant_s;
  assign s1_tready = accept_s && grant_s;

  // Frame sequencing, byte capture, lock and lock-timeout bookkeeping.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    data_d      = data_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    lock_err_d  = lock_err_q;
    to_cnt_d    = to_cnt_q;
    armed_d     = 1'b1;
    baud_wrap_s = (baud_q == BAUD_LAST);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d  = START;
          baud_d   = '0;
          bit_d    = 3'd0;
          data_d   = grant_s ? s1_tdata : s0_tdata;
          lock_d   = ~(grant_s ? s1_tlast : s0_tlast);
          owner_d  = grant_s;
          to_cnt_d = '0;
        end else if (lock_q) begin
          if (to_cnt_q == TO_LAST) begin
            lock_d     = 1'b0;
            lock_err_d = 1'b1;
            to_cnt_d   = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_ONE;
          end
        end else begin
          to_cnt_d = '0;
        end
      end
      START: begin
        if (baud_wrap_s) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_wrap_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_wrap_s) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line level and busy are derived from next-state so both come straight off flops.
  always_comb begin
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_d[bit_d];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || lock_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      data_q     <= 8'd0;
      lock_q     <= 1'b0;
      owner_q    <= 1'b1;
      lock_err_q <= 1'b0;
      to_cnt_q   <= '0;
      armed_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      lock_err_q <= lock_err_d;
      to_cnt_q   <= to_cnt_d;
      armed_q    <= armed_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign lock_err = lock_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, sys_clock cycles per UART bit (115200 baud at 100 MHz); legal minimum 2.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000000, idle cycles of the locked owner before its packet lock is forcibly released; legal minimum 1.
REQ-003 SHALL have port sys_clock, input, 1, the single clock; all logic rises on its posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports s0_tdata in 8, s0_tvalid in 1, s0_tlast in 1, s0_tready out 1: requester 0 byte stream; tlast marks the packet's final byte.
REQ-006 SHALL have ports s1_tdata, s1_tvalid, s1_tlast, s1_tready, same widths and directions: requester 1 byte stream.
REQ-007 SHALL have port uart_txd, output, 1, 8N1 serial line; idles high.
REQ-008 SHALL have port busy, output, 1, high while a frame is on the line or a packet lock is held.
REQ-009 SHALL have port owner, output, 1, index of the current or last granted requester.
REQ-010 SHALL have port lock_err, output, 1, sticky flag, set on any lock timeout.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-012 SHALL, in IDLE without a lock, grant the single requester with tvalid high; if both are high, it SHALL grant the requester that is not owner (round-robin).
REQ-013 SHALL, in IDLE with a lock held, consider only the locked owner; the other requester's tvalid SHALL be ignored.
REQ-014 SHALL assert sN_tready for exactly the one IDLE cycle in which requester N is granted and sN_tvalid is high (the accept cycle); tready SHALL be low in every other state.
REQ-015 SHALL capture tdata and tlast on the accept cycle; later changes to the inputs SHALL have no effect on the frame.
REQ-016 SHALL set the lock on acceptance of a byte with tlast=0, and clear it on acceptance of a byte with tlast=1.
REQ-017 SHALL drive uart_txd low (start bit) starting on the cycle after acceptance, for CLKS_PER_BIT cycles (START).
REQ-018 SHALL send 8 data bits LSB first, each for CLKS_PER_BIT cycles (DATA), using a 3-bit bit index and a baud counter that wraps at CLKS_PER_BIT-1.
REQ-019 SHALL drive uart_txd high for CLKS_PER_BIT cycles (STOP), then return to IDLE; frame = 10*CLKS_PER_BIT cycles, and the minimum gap to the next start bit is 1 cycle.
REQ-020 SHALL drive uart_txd high in IDLE.
REQ-021 SHALL count consecutive IDLE cycles while locked with the owner's tvalid low, and reset the count on any accept.
REQ-022 SHALL, when that count reaches LOCK_TIMEOUT, clear the lock and set lock_err; arbitration SHALL resume on the next cycle.
REQ-023 SHALL update owner on each accept cycle.

Reset
REQ-024 SHALL, while reset is high, force: state IDLE, uart_txd=1, s0_tready=s1_tready=0, busy=0, owner=1 (requester 0 wins the first tie), lock cleared, timeout count 0, lock_err=0.
REQ-025 SHALL, on reset asserted mid-frame, take uart_txd high immediately (asynchronously); the partial byte is discarded and never resent.
REQ-026 SHALL accept no byte in the first cycle after reset deassertion; arbitration SHALL begin on the second cycle.

Verification
REQ-027 CLKS_PER_BIT=4: s0 sends 0xA5 with tlast=1 -> s0_tready pulses for 1 cycle; uart_txd = 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit; 40-cycle frame; busy falls afterward.
REQ-028 Both valid after reset, single-byte packets 0x11 (s0) and 0x22 (s1) held valid -> frames alternate 0x11,0x22,0x11, and owner toggles on each accept.
REQ-029 s0 sends 3-byte packet 0x01,0x02,0x03(tlast) while s1 is valid throughout -> all three s0 frames precede any s1 frame, and s1_tready stays low until the 0x03 frame is accepted.
REQ-030 LOCK_TIMEOUT=16: s0 sends 1 byte with tlast=0 and then drops tvalid, s1 valid -> lock_err rises 16 IDLE cycles after the frame ends; s1 is accepted on the following cycle.
REQ-031 Reset pulsed during DATA bit 3 of 0xFF -> uart_txd is high in the same cycle; after release, no residual frame is sent and lock_err=0.
REQ-032 s0 changes tdata from 0x3C to 0xC3 during START -> the line carries 0x3C.
